// File: rtl/rtc_bus_sequencer_if.sv
// Request/response and strobe signals between the PicoBlaze port logic, the
// bus sequencer and the RTC chip. The bidirectional data bus stays a module port.
interface rtc_bus_sequencer_if;
  logic       req_write;
  logic       req_read;
  logic [7:0] reg_addr;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       busy;
  logic       done;
  logic       AD;
  logic       CS;
  logic       WR;
  logic       RD;

  // Requester side (I/O port logic and the RTC pins it observes).
  modport master (
    output req_write, req_read, reg_addr, wr_data,
    input  rd_data, busy, done, AD, CS, WR, RD
  );

  // Sequencer side.
  modport slave (
    input  req_write, req_read, reg_addr, wr_data,
    output rd_data, busy, done, AD, CS, WR, RD
  );
endinterface

// File: rtl/rtc_bus_sequencer.sv
// Two-phase (address, then data) bus cycle sequencer for a multiplexed-bus RTC chip.
// All control outputs and the tristate enable come straight from flops.
module rtc_bus_sequencer #(
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned PULSE_CYC = 4,
  parameter int unsigned HOLD_CYC  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  rtc_bus_sequencer_if.slave        bus,
  inout  wire  [7:0]                salient
);

  localparam logic [7:0] SetupLd = 8'(SETUP_CYC - 1);
  localparam logic [7:0] PulseLd = 8'(PULSE_CYC - 1);
  localparam logic [7:0] HoldLd  = 8'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    StIdle, StASetup, StAPulse, StAHold, StDSetup, StDPulse, StDHold, StFinish
  } state_e;

  state_e     state_q;
  logic [7:0] cnt_q;
  logic [7:0] bus_q;
  logic [7:0] data_q;
  logic [7:0] rd_data_q;
  logic       is_write_q;
  logic       drive_q;
  logic       busy_q;
  logic       done_q;
  logic       ad_q;
  logic       cs_q;
  logic       wr_q;
  logic       rd_q;
  logic       last;

  assign last = (cnt_q == 8'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= 8'd0;
      bus_q      <= 8'd0;
      data_q     <= 8'd0;
      rd_data_q  <= 8'd0;
      is_write_q <= 1'b0;
      drive_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ad_q       <= 1'b1;
      cs_q       <= 1'b1;
      wr_q       <= 1'b1;
      rd_q       <= 1'b1;
    end else begin
      // Counter idles at zero, so only timed states ever decrement it.
      if (!last) cnt_q <= cnt_q - 8'd1;
      unique case (state_q)
        StIdle: begin
          if (bus.req_write || bus.req_read) begin
            state_q    <= StASetup;
            cnt_q      <= SetupLd;
            is_write_q <= bus.req_write;
            data_q     <= bus.wr_data;
            bus_q      <= bus.reg_addr;
            drive_q    <= 1'b1;
            cs_q       <= 1'b0;
            ad_q       <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        StASetup: if (last) begin
          state_q <= StAPulse;
          cnt_q   <= PulseLd;
          wr_q    <= 1'b0;
        end
        StAPulse: if (last) begin
          state_q <= StAHold;
          cnt_q   <= HoldLd;
          wr_q    <= 1'b1;
        end
        StAHold: if (last) begin
          state_q <= StDSetup;
          cnt_q   <= SetupLd;
          ad_q    <= 1'b1;
          bus_q   <= data_q;
          // Reads release the bus here; D_SETUP doubles as turnaround.
          drive_q <= is_write_q;
        end
        StDSetup: if (last) begin
          state_q <= StDPulse;
          cnt_q   <= PulseLd;
          if (is_write_q) wr_q <= 1'b0;
          else            rd_q <= 1'b0;
        end
        StDPulse: if (last) begin
          state_q <= StDHold;
          cnt_q   <= HoldLd;
          wr_q    <= 1'b1;
          rd_q    <= 1'b1;
          if (!is_write_q) rd_data_q <= salient;
        end
        StDHold: if (last) begin
          state_q <= StFinish;
          cs_q    <= 1'b1;
          drive_q <= 1'b0;
          done_q  <= 1'b1;
        end
        StFinish: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign salient     = drive_q ? bus_q : 8'hzz;
  assign bus.rd_data = rd_data_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.AD      = ad_q;
  assign bus.CS      = cs_q;
  assign bus.WR      = wr_q;
  assign bus.RD      = rd_q;

endmodule
